// File: rtl/axi_write_buffer_q_if.sv
// AXI write-channel bundle (AW, W, B) between the write-back buffer and the memory port.
interface axi_write_buffer_q_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_write_buffer_q.sv
// Circular write-back line buffer draining oldest-first as AXI INCR bursts, with coalescing and newest-match refill query.
// Insert accepted same cycle (queryable next cycle); inserts blocked by stall_in, flush_req, or full without a coalesce hit.
module axi_write_buffer_q #(
    parameter int DEPTH        = 8,
    parameter int OFFSET_WIDTH = 3,
    parameter int PTR_W        = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [31:0]                   in_addr,
    input  logic [(32<<OFFSET_WIDTH)-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          stall_in,
    input  logic                          flush_req,
    output logic                          drained,
    output logic [PTR_W:0]                count,
    output logic                          full,
    output logic                          bus_err,
    input  logic [31:0]                   query_addr,
    output logic [(32<<OFFSET_WIDTH)-1:0] query_data,
    output logic                          query_ok,
    axi_write_buffer_q_if.master          axi
);
    localparam int BEATS = 1 << OFFSET_WIDTH;
    localparam int LINE  = BEATS * 32;
    localparam int LSB   = OFFSET_WIDTH + 2;
    localparam int TAG_W = 32 - LSB;

    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

    logic [DEPTH-1:0]        valid;
    logic [TAG_W-1:0]        tag_q [DEPTH];
    logic [LINE-1:0]         data_q [DEPTH];
    logic [PTR_W-1:0]        head, tail, coal_idx, wr_idx, qidx;
    logic [PTR_W:0]          cnt;
    state_t                  state;
    logic [OFFSET_WIDTH-1:0] beat;
    logic [LINE-1:0]         snap;
    logic [31:0]             aw_addr_q;
    logic                    awvalid_q, wvalid_q, wlast_q, bready_q, bus_err_q;
    logic                    start, head_busy, retire, coal_hit, alloc;
    logic [TAG_W-1:0]        in_tag, q_tag;
    logic                    unused_low_bits;

    assign in_tag          = in_addr[31:LSB];
    assign q_tag           = query_addr[31:LSB];
    assign unused_low_bits = ^{in_addr[LSB-1:0], query_addr[LSB-1:0]};

    // Head counts as in flight from the cycle its snapshot is taken, so a
    // same-cycle rewrite of that line allocates instead of being lost.
    assign start     = (state == S_IDLE) && (cnt != '0) && !stall_in;
    assign head_busy = (state != S_IDLE) || start;
    assign retire    = (state == S_B) && axi.bvalid;
    assign full      = (cnt == (PTR_W+1)'(DEPTH));
    assign drained   = (cnt == '0) && (state == S_IDLE);
    assign count     = cnt;
    assign bus_err   = bus_err_q;

    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && tag_q[i] == in_tag && !(head_busy && PTR_W'(i) == head)) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    assign in_ready = in_valid && !stall_in && !flush_req && (coal_hit || !full);
    assign alloc    = in_ready && !coal_hit;
    assign wr_idx   = coal_hit ? coal_idx : tail;

    // Walk oldest to newest so the last hit (closest to tail) wins.
    always_comb begin
        query_data = '0;
        query_ok   = 1'b0;
        qidx       = head;
        for (int k = 0; k < DEPTH; k++) begin
            qidx = head + PTR_W'(k);
            if (valid[qidx] && tag_q[qidx] == q_tag) begin
                query_ok   = 1'b1;
                query_data = data_q[qidx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_ready) begin
            data_q[wr_idx] <= in_data;
            tag_q[wr_idx]  <= in_tag;
        end
        if (start) begin
            snap      <= data_q[head];
            aw_addr_q <= {tag_q[head], {LSB{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid     <= '0;
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            state     <= S_IDLE;
            beat      <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (alloc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (retire) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            cnt <= cnt + {{PTR_W{1'b0}}, alloc} - {{PTR_W{1'b0}}, retire};
            case (state)
                S_IDLE: if (start) begin
                    awvalid_q <= 1'b1;
                    state     <= S_AW;
                end
                S_AW: if (axi.awready) begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b1;
                    beat      <= '0;
                    wlast_q   <= (BEATS == 1);
                    state     <= S_W;
                end
                S_W: if (axi.wready) begin
                    if (wlast_q) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        bready_q <= 1'b1;
                        state    <= S_B;
                    end else begin
                        beat    <= beat + 1'b1;
                        wlast_q <= (beat == OFFSET_WIDTH'(BEATS-2));
                    end
                end
                S_B: if (axi.bvalid) begin
                    bready_q <= 1'b0;
                    state    <= S_IDLE;
                    if (axi.bresp != 2'b00) bus_err_q <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign axi.awaddr  = aw_addr_q;
    assign axi.awlen   = 8'(BEATS-1);
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = snap[32*beat +: 32];
    assign axi.wstrb   = 4'hF;
    assign axi.wlast   = wlast_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
endmodule

// File: tb/tb_axi_write_buffer_q.sv
// Directed bench for axi_write_buffer_q; a line scoreboard checks every AW/W handshake.
module tb_axi_write_buffer_q;
    logic         clk, rstn;
    logic [31:0]  in_addr, query_addr;
    logic [255:0] in_data, query_data;
    logic         in_valid, in_ready, stall_in, flush_req;
    logic         drained, full, bus_err, query_ok;
    logic [3:0]   count;

    axi_write_buffer_q_if bus();

    axi_write_buffer_q dut (
        .clk(clk), .rstn(rstn),
        .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .stall_in(stall_in), .flush_req(flush_req),
        .drained(drained), .count(count), .full(full), .bus_err(bus_err),
        .query_addr(query_addr), .query_data(query_data), .query_ok(query_ok),
        .axi(bus)
    );

    typedef struct { logic [31:0] addr; logic [255:0] data; } line_t;
    line_t exp_q[$];
    line_t cur;
    int    wbeat;
    bit    in_burst;
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_data(input logic [31:0] base);
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[j*32 +: 32] = base + 32'(j);
        return d;
    endfunction

    task automatic insert_once(input logic [31:0] a, input logic [255:0] d, input logic exp_rdy, input string tag);
        @(posedge clk); #1;
        in_addr = a; in_data = d; in_valid = 1'b1;
        @(negedge clk);
        check(tag, in_ready, exp_rdy);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic insert_wait(input logic [31:0] a, input logic [255:0] d, input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_addr = a; in_data = d; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, in_ready, 1'b1);
        exp_q.push_back('{a, d});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drained(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!drained && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, drained, 1'b1);
    endtask

    // Scoreboard consumer: every handshake is checked against the oldest expected line.
    always @(negedge clk) begin
        if (!rstn) begin
            in_burst = 1'b0;
        end else begin
            if (bus.awvalid && bus.awready) begin
                check("aw_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("awaddr", bus.awaddr, cur.addr);
                end
                check("awlen", bus.awlen, 8'd7);
                check("awsize_burst", {bus.awsize, bus.awburst}, 5'b010_01);
                wbeat    = 0;
                in_burst = 1'b1;
            end
            if (bus.wvalid && bus.wready) begin
                check("w_in_burst", in_burst, 1'b1);
                check("wdata", bus.wdata, cur.data[wbeat*32 +: 32]);
                check("wlast", bus.wlast, wbeat == 7);
                check("wstrb", bus.wstrb, 4'hF);
                if (bus.wlast) in_burst = 1'b0;
                wbeat++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d, d_old, d_new;
        logic [31:0]  a;
        int n;
        rstn = 1'b0; in_addr = '0; in_data = '0; in_valid = 1'b0;
        stall_in = 1'b0; flush_req = 1'b0; query_addr = '0;
        bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1; bus.bresp = 2'b00;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        @(negedge clk);
        check("rst_drained", drained, 1'b1);
        check("rst_count", count, 4'd0);
        check("rst_full", full, 1'b0);
        check("rst_axi_valids", {bus.awvalid, bus.wvalid, bus.bready}, 3'b000);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_query_ok", query_ok, 1'b0);

        // Inserts are blocked by stall_in and flush_req.
        stall_in = 1'b1; in_valid = 1'b1; in_addr = 32'h1000_0020;
        #1 check("stall_blocks", in_ready, 1'b0);
        stall_in = 1'b0; flush_req = 1'b1;
        #1 check("flush_blocks", in_ready, 1'b0);
        flush_req = 1'b0; in_valid = 1'b0;

        // Single line, fully open channel.
        d = mk_data(32'h11);
        exp_q.push_back('{32'h1000_0020, d});
        insert_once(32'h1000_0020, d, 1'b1, "t1_rdy");
        query_addr = 32'h1000_0020;
        @(negedge clk);
        check("t1_query_ok", query_ok, 1'b1);
        check("t1_query_data", query_data, d);
        wait_drained("t1_drained");
        check("t1_count", count, 4'd0);
        check("t1_sb_empty", exp_q.size(), 0);

        // Fill to full behind a stalled AW, then coalesce into entry 3.
        bus.awready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 32'h2000_0000 + 32'(i * 32);
            d = mk_data(32'h2000_0000 + 32'(i * 256));
            insert_once(a, d, 1'b1, "t2_fill_rdy");
            exp_q.push_back('{a, d});
        end
        @(negedge clk);
        check("t2_full", full, 1'b1);
        check("t2_count8", count, 4'd8);
        insert_once(32'h2000_1000, mk_data(32'h9999_0000), 1'b0, "t2_full_reject");
        d_old = mk_data(32'h2000_0300);
        d_new = mk_data(32'h2300_0000);
        @(posedge clk); #1;
        in_addr = 32'h2000_0060; in_data = d_new; in_valid = 1'b1; query_addr = 32'h2000_0060;
        @(negedge clk);
        check("t2_coalesce_rdy", in_ready, 1'b1);
        check("t2_query_pre_insert", query_data, d_old);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q[3].data = d_new;
        @(negedge clk);
        check("t2_query_post_insert", query_data, d_new);
        check("t2_count_kept", count, 4'd8);
        bus.awready = 1'b1;
        wait_drained("t2_drained");
        check("t2_sb_empty", exp_q.size(), 0);

        // Rewrite of the in-flight line allocates a fresh entry.
        bus.wready = 1'b0;
        d_old = mk_data(32'h3100_0000);
        d_new = mk_data(32'h3200_0000);
        exp_q.push_back('{32'h3000_0040, d_old});
        insert_once(32'h3000_0040, d_old, 1'b1, "t3_rdy");
        n = 0;
        @(negedge clk);
        while (!bus.wvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t3_in_w", bus.wvalid, 1'b1);
        insert_once(32'h3000_0040, d_new, 1'b1, "t3_reinsert_rdy");
        exp_q.push_back('{32'h3000_0040, d_new});
        query_addr = 32'h3000_0040;
        @(negedge clk);
        check("t3_count2", count, 4'd2);
        check("t3_query_newest", query_data, d_new);
        check("t3_wdata_old", bus.wdata, 32'h3100_0000);
        bus.wready = 1'b1;
        wait_drained("t3_drained");
        check("t3_sb_empty", exp_q.size(), 0);

        // Many lines with continuous draining: pointers wrap repeatedly.
        for (int i = 0; i < 12; i++)
            insert_wait(32'h4000_0000 + 32'(i * 32), mk_data(32'h4000_0000 + 32'(i * 256)), "t4_rdy");
        wait_drained("t4_drained");
        check("t4_sb_empty", exp_q.size(), 0);

        // Error response on first burst: sticky bus_err, entry retired, next burst proceeds.
        bus.bvalid = 1'b0;
        exp_q.push_back('{32'h5000_0000, mk_data(32'h5100_0000)});
        insert_once(32'h5000_0000, mk_data(32'h5100_0000), 1'b1, "t5_rdy0");
        exp_q.push_back('{32'h5000_0020, mk_data(32'h5200_0000)});
        insert_once(32'h5000_0020, mk_data(32'h5200_0000), 1'b1, "t5_rdy1");
        n = 0;
        @(negedge clk);
        while (!bus.bready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_bready", bus.bready, 1'b1);
        bus.bresp = 2'b10; bus.bvalid = 1'b1;
        @(posedge clk); #1;
        bus.bresp = 2'b00;
        @(negedge clk);
        check("t5_bus_err_set", bus_err, 1'b1);
        check("t5_count_after_err", count, 4'd1);
        wait_drained("t5_drained");
        check("t5_bus_err_sticky", bus_err, 1'b1);
        check("t5_sb_empty", exp_q.size(), 0);

        // Reset in the middle of W beat 3.
        d = mk_data(32'h6600_0000);
        exp_q.push_back('{32'h6000_0080, d});
        query_addr = 32'h6000_0080;
        insert_once(32'h6000_0080, d, 1'b1, "t6_rdy");
        n = 0;
        @(negedge clk);
        while (!(bus.wvalid && bus.wdata == 32'h6600_0003) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_beat3", bus.wdata, 32'h6600_0003);
        check("t6_query_inflight", query_ok, 1'b1);
        #1 rstn = 1'b0;
        #1;
        check("t6_rst_wvalid", bus.wvalid, 1'b0);
        check("t6_rst_count", count, 4'd0);
        check("t6_rst_query_ok", query_ok, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("t6_drained", drained, 1'b1);
        check("t6_bus_err_clear", bus_err, 1'b0);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_write_buffer_q.md
Name: axi_write_buffer_q

Overview:
- Parametrised circular write-back buffer between the data cache (victim/line writes) and the AXI master port.
- Accepts full cache lines and drains them oldest-first as AXI INCR bursts (AW, W beats, B).
- Coalesces repeated writes to a line already queued.
- Serves cache refills through a combinational newest-match query.

Parameters:
DEPTH, 8, number of line entries (power of two, at least 2)
OFFSET_WIDTH, 3, log2 of 32-bit words per line; BEATS = 1<<OFFSET_WIDTH, LINE = BEATS*32
PTR_W, $clog2(DEPTH), pointer width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_addr  in  32  line address (low OFFSET_WIDTH+2 bits ignored)
in_data  in  LINE  line data, word 0 in [31:0]
in_valid  in  1  insert request
in_ready  out  1  insert accepted this cycle (combinational)
stall_in  in  1  DMA/coherence hold; blocks inserts
flush_req  in  1  level; blocks inserts until buffer is drained
drained  out  1  empty and FSM in IDLE
count  out  PTR_W+1  valid entries, including the one in flight
full  out  1  count==DEPTH
awaddr  out  32  head address, low OFFSET_WIDTH+2 bits zeroed
awlen  out  8  BEATS-1
awsize  out  3  3'b010
awburst  out  2  2'b01 (INCR)
awvalid / awready  out / in  1  AW handshake
wdata  out  32  current beat
wstrb  out  4  4'hF
wlast  out  1  final beat
wvalid / wready  out / in  1  W handshake
bresp  in  2  write response
bvalid / bready  in / out  1  B handshake
bus_err  out  1  sticky, set on bresp!=0, cleared only by reset
query_addr  in  32  refill lookup address
query_data  out  LINE  newest matching data, 0 on miss
query_ok  out  1  hit

Behaviour:
- Reset:
  - head, tail, count = 0; all valid bits = 0; FSM = IDLE.
  - All AXI valid/ready outputs = 0; bus_err = 0; drained = 1.
  - A reset during a burst abandons the burst; no resume.
- Line match: compare addr[31:OFFSET_WIDTH+2].
- Insert acceptance: in_ready = in_valid & !stall_in & !flush_req & (hit_coalescible | !full).
  - Data is written at the clock edge of acceptance and is queryable the next cycle.
- Coalesce: the incoming line matches a valid entry that is not the in-flight head.
  - Overwrite that entry's data in place; count and tail unchanged.
  - If the line matches only the in-flight head, allocate a new tail entry (requires !full).
- Otherwise allocate at tail; tail wraps DEPTH-1 -> 0.
- Drain FSM:
  - IDLE: if count!=0, go to AW and snapshot the head data into a LINE-wide register.
  - AW: awvalid=1 with awaddr from head. On awready, go to W with beat=0.
  - W: wvalid=1, wdata = snapshot[beat*32 +: 32], wlast = (beat==BEATS-1).
    - On wready, beat+1.
    - On wready with wlast, go to B.
  - B: bready=1. On bvalid:
    - clear the head valid bit; head+1 with wrap; go to IDLE.
    - if bresp!=0, set bus_err (entry is still retired).
- AXI outputs are held stable while valid is high and ready is low.
- Simultaneous insert-allocate and B retire in one cycle: count unchanged; both pointers advance.
- When full with no coalesce hit, in_ready=0; the retire in that cycle frees a slot for the next cycle only.
- Query:
  - Combinational over all valid entries, including the in-flight head.
  - Priority goes to the newest entry (closest to tail).
  - query_data = 0 and query_ok = 0 on miss.
  - Insert and query on the same line in one cycle return the pre-insert data.
- No AW is issued while stall_in=1 and FSM is IDLE; a burst already started completes.

Test Plan:
- Reset, insert A=0x1000_0020 with data words 0..7 = 0x11..0x18, awready/wready/bvalid tied high -> awaddr 0x1000_0020, awlen 7, eight beats 0x11..0x18, wlast on beat 7, count returns to 0, drained=1.
- Hold awready=0; insert 8 distinct lines -> full=1, count=8; a 9th new address sees in_ready=0; a 9th insert matching entry 3 is accepted and coalesced, count stays 8.
- Insert X, then insert X again with new data while X is in W phase -> the burst sends the old data, count=2, query X returns the new data.
- Insert lines sequentially to wrap tail past DEPTH-1 with continuous draining -> AW addresses leave in insertion order, no entry lost.
- Return bresp=2'b10 on the first burst -> bus_err=1 and stays 1; the entry is retired and the next burst proceeds.
- Assert rstn low mid-W (beat 3) -> wvalid=0, count=0, query_ok=0 immediately; after release, drained=1.
